// File: rtl/register_bank_2w.sv
// register_bank_2w
//   Parametrised register file: DEPTH words of WIDTH data bits plus one h
//   (high/flag) bit each. Two write ports let two registers update on the
//   same edge, and two combinational read ports serve operand fetch. A busy
//   scoreboard bit per register lets the issue stage stall on pending writes.
//
// Parameters
//   WIDTH   data bits per register (h bit is extra)
//   DEPTH   number of registers, power of two, >= 2
//   AW      address width, equal to log2(DEPTH)
//   BYPASS  1: same-cycle write data is forwarded to reads; 0: reads show stored value
//
// Ports
//   CLK                      clock, all state updates on the rising edge
//   Reset                    asynchronous, active-low reset
//   we0/wa0/wd0/wh0          write port 0: enable, address, data, h bit
//   we1/wa1/wd1/wh1          write port 1 (wins over port 0 on equal address)
//   rsv_en/rsv_addr          mark a register busy (pending producer)
//   ra_a -> rd_a/rh_a/rbusy_a   read port A: data, h bit, stored busy bit
//   ra_b -> rd_b/rh_b/rbusy_b   read port B
//   wr_conflict              one-cycle pulse: both ports wrote one address last cycle

module register_bank_2w #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             wh0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1,
  input  logic             wh1,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    ra_a,
  output logic [WIDTH-1:0] rd_a,
  output logic             rh_a,
  output logic             rbusy_a,
  input  logic [AW-1:0]    ra_b,
  output logic [WIDTH-1:0] rd_b,
  output logic             rh_b,
  output logic             rbusy_b,
  output logic             wr_conflict
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic             h_q    [DEPTH];
  logic             h_d    [DEPTH];
  logic             busy_q [DEPTH];
  logic             busy_d [DEPTH];
  logic             conflict_q;
  logic             conflict_d;

  // Next-state for the storage and scoreboard. Port 1 is applied after
  // port 0 so it wins on an address collision. The reserve is applied last
  // so a new producer keeps the register busy even if it is written now.
  always_comb begin
    data_d = data_q;
    h_d    = h_q;
    busy_d = busy_q;
    if (we0) begin
      data_d[wa0] = wd0;
      h_d[wa0]    = wh0;
      busy_d[wa0] = 1'b0;
    end
    if (we1) begin
      data_d[wa1] = wd1;
      h_d[wa1]    = wh1;
      busy_d[wa1] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[rsv_addr] = 1'b1;
    end
    conflict_d = we0 && we1 && (wa0 == wa1);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        h_q[i]    <= 1'b0;
        busy_q[i] <= 1'b0;
      end
      conflict_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      h_q        <= h_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign wr_conflict = conflict_q;

  // Read port A. Outputs are forced to zero while reset is held so nothing
  // forwarded from the write ports leaks out during reset. Busy is never
  // bypassed: it always reflects the stored scoreboard.
  always_comb begin
    rd_a    = '0;
    rh_a    = 1'b0;
    rbusy_a = 1'b0;
    if (Reset) begin
      rd_a    = data_q[ra_a];
      rh_a    = h_q[ra_a];
      rbusy_a = busy_q[ra_a];
      if (BYPASS) begin
        if (we0 && (wa0 == ra_a)) begin
          rd_a = wd0;
          rh_a = wh0;
        end
        if (we1 && (wa1 == ra_a)) begin
          rd_a = wd1;
          rh_a = wh1;
        end
      end
    end
  end

  // Read port B, identical to port A.
  always_comb begin
    rd_b    = '0;
    rh_b    = 1'b0;
    rbusy_b = 1'b0;
    if (Reset) begin
      rd_b    = data_q[ra_b];
      rh_b    = h_q[ra_b];
      rbusy_b = busy_q[ra_b];
      if (BYPASS) begin
        if (we0 && (wa0 == ra_b)) begin
          rd_b = wd0;
          rh_b = wh0;
        end
        if (we1 && (wa1 == ra_b)) begin
          rd_b = wd1;
          rh_b = wh1;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_bank_2w.sv
// tb_register_bank_2w
//   Drives a BYPASS=1 and a BYPASS=0 instance of register_bank_2w with the
//   same inputs and compares both against a behavioural array model kept in
//   the bench: directed scenarios first, then random traffic, then a
//   mid-cycle reset.

module tb_register_bank_2w;

  logic        CLK;
  logic        Reset;
  logic        we0, we1, wh0, wh1, rsv_en;
  logic [3:0]  wa0, wa1, rsv_addr, ra_a, ra_b;
  logic [31:0] wd0, wd1;

  logic [31:0] rd_a1, rd_b1, rd_a0, rd_b0;
  logic        rh_a1, rh_b1, rh_a0, rh_b0;
  logic        rbusy_a1, rbusy_b1, rbusy_a0, rbusy_b0;
  logic        conflict1, conflict0;

  int vectors;
  int miscompares;

  // Reference model state
  logic [31:0] memData [16];
  logic        memH    [16];
  logic        memBusy [16];
  logic        conflictExp;

  register_bank_2w #(.WIDTH(32), .DEPTH(16), .AW(4), .BYPASS(1'b1)) dutBypass (
    .CLK(CLK), .Reset(Reset),
    .we0(we0), .wa0(wa0), .wd0(wd0), .wh0(wh0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .wh1(wh1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra_a(ra_a), .rd_a(rd_a1), .rh_a(rh_a1), .rbusy_a(rbusy_a1),
    .ra_b(ra_b), .rd_b(rd_b1), .rh_b(rh_b1), .rbusy_b(rbusy_b1),
    .wr_conflict(conflict1)
  );

  register_bank_2w #(.WIDTH(32), .DEPTH(16), .AW(4), .BYPASS(1'b0)) dutStored (
    .CLK(CLK), .Reset(Reset),
    .we0(we0), .wa0(wa0), .wd0(wd0), .wh0(wh0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .wh1(wh1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra_a(ra_a), .rd_a(rd_a0), .rh_a(rh_a0), .rbusy_a(rbusy_a0),
    .ra_b(ra_b), .rd_b(rd_b0), .rh_b(rh_b0), .rbusy_b(rbusy_b0),
    .wr_conflict(conflict0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic compareValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      memData[i] = '0;
      memH[i]    = 1'b0;
      memBusy[i] = 1'b0;
    end
    conflictExp = 1'b0;
  endtask

  // Expected {h, data} seen on a read port; a pending write is visible only
  // when forwarding is enabled, and the later port takes priority.
  function automatic logic [63:0] expRead(input logic [3:0] a, input bit byp);
    logic [32:0] v;
    if (!Reset) return 64'd0;
    v = {memH[a], memData[a]};
    if (byp && we0 && wa0 == a) v = {wh0, wd0};
    if (byp && we1 && wa1 == a) v = {wh1, wd1};
    return {31'd0, v};
  endfunction

  function automatic logic [63:0] expBusy(input logic [3:0] a);
    return Reset ? {63'd0, memBusy[a]} : 64'd0;
  endfunction

  // What a rising edge does to the model: writes in port order, then
  // reserve, and the conflict pulse reflects the cycle just ended.
  task automatic updateModel();
    if (!Reset) return;
    conflictExp = we0 && we1 && (wa0 == wa1);
    if (we0) begin memData[wa0] = wd0; memH[wa0] = wh0; memBusy[wa0] = 1'b0; end
    if (we1) begin memData[wa1] = wd1; memH[wa1] = wh1; memBusy[wa1] = 1'b0; end
    if (rsv_en) memBusy[rsv_addr] = 1'b1;
  endtask

  task automatic checkOutput(input string phase);
    compareValue({phase, " rdA byp"},   {31'd0, rh_a1, rd_a1}, expRead(ra_a, 1'b1));
    compareValue({phase, " rdB byp"},   {31'd0, rh_b1, rd_b1}, expRead(ra_b, 1'b1));
    compareValue({phase, " rdA nobyp"}, {31'd0, rh_a0, rd_a0}, expRead(ra_a, 1'b0));
    compareValue({phase, " rdB nobyp"}, {31'd0, rh_b0, rd_b0}, expRead(ra_b, 1'b0));
    compareValue({phase, " busyA"},     {63'd0, rbusy_a1}, expBusy(ra_a));
    compareValue({phase, " busyB"},     {63'd0, rbusy_b1}, expBusy(ra_b));
    compareValue({phase, " busyA nobyp"}, {63'd0, rbusy_a0}, expBusy(ra_a));
    compareValue({phase, " conflict"},  {63'd0, conflict1}, {63'd0, conflictExp});
    compareValue({phase, " conflict nobyp"}, {63'd0, conflict0}, {63'd0, conflictExp});
  endtask

  task automatic clearInputs();
    we0 = 1'b0; wa0 = '0; wd0 = '0; wh0 = 1'b0;
    we1 = 1'b0; wa1 = '0; wd1 = '0; wh1 = 1'b0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  // One cycle: inputs are already set after a falling edge; check before
  // the rising edge, advance the model on it, and return at the next fall.
  task automatic applyStimulus(input string phase);
    #1 checkOutput(phase);
    @(posedge CLK);
    updateModel();
    @(negedge CLK);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    modelReset();
    clearInputs();
    ra_a  = '0;
    ra_b  = '0;
    Reset = 1'b0;

    // Held in reset: outputs zero, writes ignored
    @(negedge CLK);
    we0 = 1'b1; wa0 = 4'd2; wd0 = 32'hFFFF_0000; wh0 = 1'b1; ra_a = 4'd2;
    applyStimulus("inReset");
    clearInputs();
    Reset = 1'b1;

    // All registers read zero after reset
    for (int i = 0; i < 16; i++) begin
      ra_a = 4'(i);
      ra_b = 4'(15 - i);
      applyStimulus("resetRead");
    end

    // Dual write to distinct addresses
    we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEADBEEF; wh0 = 1'b1;
    we1 = 1'b1; wa1 = 4'd9; wd1 = 32'h12345678; wh1 = 1'b0;
    ra_a = 4'd3; ra_b = 4'd9;
    applyStimulus("dualWr");
    clearInputs();
    applyStimulus("dualRd");

    // Same-address write: port 1 wins, conflict pulses once
    we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h1; wh0 = 1'b0;
    we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h2; wh1 = 1'b1;
    ra_a = 4'd5; ra_b = 4'd3;
    applyStimulus("conflictWr");
    clearInputs();
    applyStimulus("conflictPulse");
    applyStimulus("conflictDone");

    // Forwarding of a same-cycle write (bypass vs stored instance)
    we0 = 1'b1; wa0 = 4'd7; wd0 = 32'hA5A5A5A5; wh0 = 1'b1;
    ra_a = 4'd7; ra_b = 4'd7;
    applyStimulus("bypassWr");
    clearInputs();
    applyStimulus("bypassRd");

    // Scoreboard: reserve, clear by write, reserve + write together, re-reserve
    ra_a = 4'd4; ra_b = 4'd4;
    rsv_en = 1'b1; rsv_addr = 4'd4;
    applyStimulus("rsv");
    clearInputs();
    applyStimulus("rsvHeld");
    we1 = 1'b1; wa1 = 4'd4; wd1 = 32'h44;
    applyStimulus("wrClears");
    clearInputs();
    applyStimulus("busyCleared");
    rsv_en = 1'b1; rsv_addr = 4'd4; we0 = 1'b1; wa0 = 4'd4; wd0 = 32'h55;
    applyStimulus("rsvAndWr");
    clearInputs();
    applyStimulus("busyStays");
    rsv_en = 1'b1; rsv_addr = 4'd4;
    applyStimulus("reRsv");
    clearInputs();
    applyStimulus("reRsvHeld");

    // Random traffic with frequent address collisions
    for (int n = 0; n < 300; n++) begin
      we0      = 1'($urandom);
      we1      = 1'($urandom);
      wa0      = 4'($urandom);
      wa1      = ($urandom_range(0, 3) == 0) ? wa0 : 4'($urandom);
      wd0      = $urandom;
      wd1      = $urandom;
      wh0      = 1'($urandom);
      wh1      = 1'($urandom);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wa1 : 4'($urandom);
      ra_a     = ($urandom_range(0, 2) == 0) ? wa0 : 4'($urandom);
      ra_b     = ($urandom_range(0, 2) == 0) ? wa1 : 4'($urandom);
      applyStimulus("random");
    end

    // Fill every register with a nonzero value
    clearInputs();
    for (int i = 0; i < 16; i += 2) begin
      we0 = 1'b1; wa0 = 4'(i);     wd0 = 32'hC000_0000 | 32'(i); wh0 = 1'b1;
      we1 = 1'b1; wa1 = 4'(i + 1); wd1 = 32'hC000_0000 | 32'(i + 1); wh1 = 1'b0;
      applyStimulus("fill");
    end
    clearInputs();
    ra_a = 4'd6; ra_b = 4'd11;
    rsv_en = 1'b1; rsv_addr = 4'd6;
    applyStimulus("filled");
    clearInputs();
    we0 = 1'b1; wa0 = 4'd6; wd0 = 32'h0BAD_0BAD; wh0 = 1'b1;
    #1 checkOutput("preReset");

    // Reset between edges clears everything at once
    @(posedge CLK);
    updateModel();
    #3;
    Reset = 1'b0;
    modelReset();
    #1 checkOutput("midReset");
    @(negedge CLK);
    we1 = 1'b1; wa1 = 4'd11; wd1 = 32'hFFFF_FFFF; wh1 = 1'b1;
    applyStimulus("wrInReset");
    applyStimulus("wrInReset2");
    clearInputs();
    Reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ra_a = 4'(i);
      ra_b = 4'(15 - i);
      applyStimulus("postReset");
    end

    // Normal operation resumes after release
    we0 = 1'b1; wa0 = 4'd1; wd0 = 32'h0000_1111; wh0 = 1'b1;
    ra_a = 4'd1;
    applyStimulus("resumeWr");
    clearInputs();
    applyStimulus("resumeRd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
